// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsubState;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cntWidth(input int nDigits);
    return (nDigits > 1) ? $clog2(nDigits) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple slice; exposes the carry into its MSB for overflow.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]         = x[i] ^ y[i] ^ carry[i];
      carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = carry[DIGIT];
  assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, least-significant digit first.
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | one digit per cycle, busy=1
//   DONE  | single-cycle done pulse, may accept a new start
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cntWidth(NDIG);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
    $error("digit_serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  addsubState      state, stateNext;
  logic [WIDTH-1:0] aShift, bShift;
  logic            subLat;
  logic            carryReg;
  logic [CW-1:0]   digitCnt;
  logic            lastDigit;
  logic            accept;
  logic [DIGIT-1:0] sumDig;
  logic            digitCout;
  logic            digitMsbIn;

  assign lastDigit = (digitCnt == CW'(NDIG - 1));
  assign accept    = start && (state != RUN);

  // b is inverted digit by digit; the +1 of two's complement comes from carryReg
  digit_adder #(.DIGIT(DIGIT)) uDigitAdder (
    .x        (aShift[DIGIT-1:0]),
    .y        (bShift[DIGIT-1:0] ^ {DIGIT{subLat}}),
    .cin      (carryReg),
    .s        (sumDig),
    .cout     (digitCout),
    .c_msb_in (digitMsbIn)
  );

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) stateNext = RUN;
      RUN: begin
        busy = 1'b1;
        if (lastDigit) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      aShift    <= '0;
      bShift    <= '0;
      subLat    <= 1'b0;
      carryReg  <= 1'b0;
      digitCnt  <= '0;
      y         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        aShift   <= a;
        bShift   <= b;
        subLat   <= sub;
        carryReg <= sub;
        digitCnt <= '0;
        y        <= '0;
      end else if (state == RUN) begin
        aShift   <= aShift >> DIGIT;
        bShift   <= bShift >> DIGIT;
        carryReg <= digitCout;
        digitCnt <= digitCnt + 1'b1;
        y[digitCnt*DIGIT +: DIGIT] <= sumDig;
        if (lastDigit) begin
          carry_out <= digitCout;
          overflow  <= digitCout ^ digitMsbIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: four WIDTH=8 instances (DIGIT 1,2,4,8), directed and random ops.
module tb_digit_serial_addsub;

  logic       clk = 1'b0;
  logic [3:0] rstV   = 4'hF;
  logic [3:0] startV = 4'h0;
  logic [3:0] subV   = 4'h0;
  logic [7:0] aV [4];
  logic [7:0] bV [4];
  logic [3:0] busyV, doneV, coV, ovV;
  logic [7:0] yV [4];

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    digit_serial_addsub #(.WIDTH(8), .DIGIT(1 << g)) uDut (
      .clk       (clk),
      .rst       (rstV[g]),
      .start     (startV[g]),
      .sub       (subV[g]),
      .a         (aV[g]),
      .b         (bV[g]),
      .busy      (busyV[g]),
      .done      (doneV[g]),
      .y         (yV[g]),
      .carry_out (coV[g]),
      .overflow  (ovV[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operation
  function automatic void model(input int av, input int bv, input int sv,
                                output int yE, output int cE, output int oE);
    int full, sa, sb, r;
    full = sv ? av + (255 - bv) + 1 : av + bv;
    yE   = full % 256;
    cE   = (full / 256) % 2;
    sa   = (av > 127) ? av - 256 : av;
    sb   = (bv > 127) ? bv - 256 : bv;
    r    = sv ? sa - sb : sa + sb;
    oE   = (r < -128 || r > 127) ? 1 : 0;
  endfunction

  task automatic startOp(input int lane, input int av, input int bv, input int sv);
    @(negedge clk);
    aV[lane]     = av[7:0];
    bV[lane]     = bv[7:0];
    subV[lane]   = sv[0];
    startV[lane] = 1'b1;
    @(posedge clk);
    #1;
    startV[lane] = 1'b0;
  endtask

  task automatic waitDone(input int lane, output int edges, output int busyCnt);
    int overlap;
    edges   = 0;
    busyCnt = 0;
    overlap = 0;
    while (!doneV[lane] && edges < 64) begin
      if (busyV[lane]) busyCnt++;
      if (busyV[lane] && doneV[lane]) overlap++;
      @(posedge clk);
      #1;
      edges++;
    end
    chk($sformatf("lane%0d.doneSeen", lane), int'(doneV[lane]), 1);
    chk($sformatf("lane%0d.busyAtDone", lane), int'(busyV[lane]), 0);
    if (overlap != 0) chk($sformatf("lane%0d.busyDoneOverlap", lane), overlap, 0);
  endtask

  task automatic checkRes(input int lane, input int av, input int bv, input int sv,
                          input string tag);
    int yE, cE, oE;
    model(av, bv, sv, yE, cE, oE);
    chk({tag, ".y"}, int'(yV[lane]), yE);
    chk({tag, ".carry"}, int'(coV[lane]), cE);
    chk({tag, ".ovf"}, int'(ovV[lane]), oE);
  endtask

  task automatic runOp(input int lane, input int av, input int bv, input int sv,
                       input string tag);
    int e, bc;
    startOp(lane, av, bv, sv);
    waitDone(lane, e, bc);
    chk({tag, ".latency"}, e, 8 >> lane);
    chk({tag, ".busyCycles"}, bc, 8 >> lane);
    checkRes(lane, av, bv, sv, tag);
    @(posedge clk);
    #1;
    chk({tag, ".donePulse"}, int'(doneV[lane]), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, bc, nDone;
    int corners [5];
    corners = '{0, 1, 127, 128, 255};
    for (int i = 0; i < 4; i++) begin
      aV[i] = '0;
      bV[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst%0d.busy", i), int'(busyV[i]), 0);
      chk($sformatf("rst%0d.done", i), int'(doneV[i]), 0);
      chk($sformatf("rst%0d.y", i), int'(yV[i]), 0);
      chk($sformatf("rst%0d.carry", i), int'(coV[i]), 0);
      chk($sformatf("rst%0d.ovf", i), int'(ovV[i]), 0);
    end
    @(negedge clk);
    rstV = 4'h0;

    // DIGIT=2 directed cases
    runOp(1, 200, 100, 0, "d2.200p100");
    runOp(1, 100, 100, 0, "d2.100p100");

    // reset during the second RUN cycle discards the operation
    startOp(1, 8'h55, 8'h55, 0);
    @(posedge clk);
    #1;
    chk("rstMid.busyBefore", int'(busyV[1]), 1);
    rstV[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("rstMid.busy", int'(busyV[1]), 0);
    chk("rstMid.y", int'(yV[1]), 0);
    chk("rstMid.ovf", int'(ovV[1]), 0);
    chk("rstMid.carry", int'(coV[1]), 0);
    rstV[1] = 1'b0;
    nDone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (doneV[1]) nDone++;
    end
    chk("rstMid.noDone", nDone, 0);

    runOp(1, 5, 7, 1, "d2.5m7");

    // start and operand changes while busy are ignored
    startOp(1, 3, 9, 1);
    aV[1]     = 8'hFF;
    bV[1]     = 8'hFF;
    subV[1]   = 1'b0;
    startV[1] = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    startV[1] = 1'b0;
    waitDone(1, e, bc);
    chk("ignore.latency", e + 2, 4);
    checkRes(1, 3, 9, 1, "ignore");
    @(posedge clk);
    #1;
    chk("ignore.noRestart", int'(busyV[1]), 0);

    // DIGIT=4 with a back-to-back start issued during DONE
    startOp(2, 128, 1, 1);
    waitDone(2, e, bc);
    chk("d4.128m1.latency", e, 2);
    checkRes(2, 128, 1, 1, "d4.128m1");
    aV[2]     = 8'd77;
    bV[2]     = 8'd200;
    subV[2]   = 1'b0;
    startV[2] = 1'b1;
    @(posedge clk);
    #1;
    startV[2] = 1'b0;
    chk("b2b.busy", int'(busyV[2]), 1);
    waitDone(2, e, bc);
    chk("b2b.edgesFromDone", e + 1, 3);
    checkRes(2, 77, 200, 0, "b2b");

    // corners and random operands on every digit size
    for (int lane = 0; lane < 4; lane++) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          for (int s = 0; s < 2; s++)
            runOp(lane, corners[i], corners[j], s,
                  $sformatf("c%0d.%0d.%0d.%0d", lane, corners[i], corners[j], s));
      for (int n = 0; n < 120; n++) begin
        int ra, rb, rs;
        ra = int'($urandom_range(255, 0));
        rb = int'($urandom_range(255, 0));
        rs = int'($urandom_range(1, 0));
        runOp(lane, ra, rb, rs, $sformatf("r%0d.%0d.%0d.%0d", lane, ra, rb, rs));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
